// File: rtl/hs_bit_packer.sv
// Packs the serial bit stream coming out of the packet arbiter into WORD_WD-bit words.
// Optional macro HS_BIT_PACKER_MSB_FIRST_EN: place the first bit of each word at the MSB.
module hs_bit_packer #(
   parameter int WORD_WD = 8,
   parameter int CNT_WD  = $clog2(WORD_WD + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   input  logic               data_in,
   input  logic               last_in,
   output logic               ready_in,
   output logic               valid_out,
   output logic [WORD_WD-1:0] data_out,
   output logic [CNT_WD-1:0]  bit_cnt_out,
   output logic               last_out,
   input  logic               ready_out
);

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_e;

   acc_state_e         state_q, state_d;
   logic [WORD_WD-1:0] acc_r_q, acc_r_d;
   logic [CNT_WD-1:0]  acc_cnt_q, acc_cnt_d;
   logic               acc_last_q, acc_last_d;

   logic               valid_out_q, valid_out_d;
   logic [WORD_WD-1:0] data_out_q, data_out_d;
   logic [CNT_WD-1:0]  bit_cnt_q, bit_cnt_d;
   logic               last_out_q, last_out_d;

   logic               acc_done;
   logic               xfer;
   logic               fire_in;
   logic [WORD_WD-1:0] base_r;
   logic [CNT_WD-1:0]  base_cnt;
   logic [CNT_WD-1:0]  wr_idx;
   logic               word_full;

   assign acc_done = (state_q == HOLD);

   // The output register accepts the held word when empty or draining this cycle.
   always_comb begin
      xfer     = acc_done && (!valid_out_q || ready_out);
      ready_in = !acc_done || xfer;
      fire_in  = valid_in && ready_in;
   end

   // A transfer empties the accumulator first, so a bit accepted in the same
   // cycle starts the next word at index 0.
   always_comb begin
      base_r    = xfer ? '0 : acc_r_q;
      base_cnt  = xfer ? '0 : acc_cnt_q;
      word_full = (base_cnt == CNT_WD'(WORD_WD - 1));
`ifdef HS_BIT_PACKER_MSB_FIRST_EN
      wr_idx    = CNT_WD'(WORD_WD - 1) - base_cnt;
`else
      wr_idx    = base_cnt;
`endif
   end

   always_comb begin
      state_d    = state_q;
      acc_r_d    = base_r;
      acc_cnt_d  = base_cnt;
      acc_last_d = acc_last_q;
      if (xfer) begin
         state_d    = ACC;
         acc_last_d = 1'b0;
      end
      if (fire_in) begin
         for (int i = 0; i < WORD_WD; i++) begin
            if (wr_idx == CNT_WD'(i)) acc_r_d[i] = data_in;
         end
         acc_cnt_d  = base_cnt + CNT_WD'(1);
         acc_last_d = last_in;
         if (word_full || last_in) state_d = HOLD;
      end
   end

   always_comb begin
      valid_out_d = valid_out_q;
      data_out_d  = data_out_q;
      bit_cnt_d   = bit_cnt_q;
      last_out_d  = last_out_q;
      if (xfer) begin
         valid_out_d = 1'b1;
         data_out_d  = acc_r_q;
         bit_cnt_d   = acc_cnt_q;
         last_out_d  = acc_last_q;
      end else if (valid_out_q && ready_out) begin
         valid_out_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         acc_r_q     <= '0;
         acc_cnt_q   <= '0;
         acc_last_q  <= 1'b0;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
         bit_cnt_q   <= '0;
         last_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_r_q     <= acc_r_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_last_q  <= acc_last_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
         bit_cnt_q   <= bit_cnt_d;
         last_out_q  <= last_out_d;
      end
   end

   assign valid_out   = valid_out_q;
   assign data_out    = data_out_q;
   assign bit_cnt_out = bit_cnt_q;
   assign last_out    = last_out_q;

endmodule
